// File: rtl/avg_pkg.sv
// ============================================================================
// Module      : avg_pkg
// Description : Shared types and defaults for the line rasterizer: pixel
//               coordinate and colour types, rasterizer state encoding and
//               the default screen extent used for optional clipping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avg_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [2:0]  color_t;

  typedef enum logic [0:0] {
    RAST_IDLE = 1'b0,
    RAST_DRAW = 1'b1
  } rast_state_t;

  localparam int AVG_SCREEN_W = 640;
  localparam int AVG_SCREEN_H = 480;

endpackage

`default_nettype wire

// File: rtl/avg_bres_step.sv
// ============================================================================
// Module      : avg_bres_step
// Description : Combinational Bresenham step. From the current pixel, end
//               point, step directions, deltas and error term it produces the
//               next pixel, the next error term, and whether the current pixel
//               is the last one of the line.
// Ports       : x, y          current pixel
//               x1, y1        line end point
//               sx_neg/sy_neg step direction is -1 when set, +1 otherwise
//               dx, dy        absolute deltas (12-bit)
//               err           current error term (13-bit signed)
//               x_next/y_next next pixel
//               err_next      next error term
//               last          current pixel equals the end point
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avg_bres_step
  import avg_pkg::*;
(
  input  coord_t             x,
  input  coord_t             y,
  input  coord_t             x1,
  input  coord_t             y1,
  input  logic               sx_neg,
  input  logic               sy_neg,
  input  logic [11:0]        dx,
  input  logic [11:0]        dy,
  input  logic signed [12:0] err,
  output coord_t             x_next,
  output coord_t             y_next,
  output logic signed [12:0] err_next,
  output logic               last
);

  // 2*err needs one more bit than err; deltas are zero-extended to match.
  logic signed [13:0] e2;
  logic signed [13:0] dx_w;
  logic signed [13:0] dy_w;
  logic               step_x;
  logic               step_y;
  logic signed [12:0] err_x;

  assign e2   = {err, 1'b0};
  assign dx_w = {2'b00, dx};
  assign dy_w = {2'b00, dy};

  // Strict comparisons on both axes: ties favour the minor axis stepping
  // later, and both conditions can only be false together for dx=dy=0.
  assign step_x = (e2 > -dy_w);
  assign step_y = (e2 < dx_w);

  assign err_x    = step_x ? (err - $signed({1'b0, dy})) : err;
  assign err_next = step_y ? (err_x + $signed({1'b0, dx})) : err_x;

  assign x_next = step_x ? (sx_neg ? (x - 11'd1) : (x + 11'd1)) : x;
  assign y_next = step_y ? (sy_neg ? (y - 11'd1) : (y + 11'd1)) : y;

  assign last = (x == x1) && (y == y1);

endmodule

`default_nettype wire

// File: rtl/avg_line_raster.sv
// ============================================================================
// Module      : avg_line_raster
// Description : Pops lines from a queue and rasterizes them with integer
//               Bresenham over all octants, one pixel per cycle peak, with a
//               valid/ready handshake towards the framebuffer.
// Ports       : clk_in, rst_b (async, active-low)
//               lnStartX/Y, lnEndX/Y, lnColor, lnEmpty, lnRead : line queue
//               pixX, pixY, pixColor, pixWe, pixReady          : pixel output
//               busy                                           : drawing
// Config      : AVG_RAST_CLIP_EN - when defined, pixels outside
//               SCREEN_W x SCREEN_H are stepped through without being written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avg_line_raster
  import avg_pkg::*;
#(
  parameter int SCREEN_W = AVG_SCREEN_W,
  parameter int SCREEN_H = AVG_SCREEN_H
) (
  input  logic        clk_in,
  input  logic        rst_b,
  input  logic [10:0] lnStartX,
  input  logic [10:0] lnStartY,
  input  logic [10:0] lnEndX,
  input  logic [10:0] lnEndY,
  input  logic [2:0]  lnColor,
  input  logic        lnEmpty,
  output logic        lnRead,
  output logic [10:0] pixX,
  output logic [10:0] pixY,
  output logic [2:0]  pixColor,
  output logic        pixWe,
  input  logic        pixReady,
  output logic        busy
);

  rast_state_t        state;
  coord_t             cur_x;
  coord_t             cur_y;
  coord_t             end_x;
  coord_t             end_y;
  color_t             cur_color;
  logic               sx_neg;
  logic               sy_neg;
  logic [11:0]        dx;
  logic [11:0]        dy;
  logic signed [12:0] err;

  coord_t             x_next;
  coord_t             y_next;
  logic signed [12:0] err_next;
  logic               last;
  logic               visible;
  logic               advance;
  logic [11:0]        head_dx;
  logic [11:0]        head_dy;

  assign head_dx = (lnEndX >= lnStartX) ? {1'b0, lnEndX - lnStartX}
                                        : {1'b0, lnStartX - lnEndX};
  assign head_dy = (lnEndY >= lnStartY) ? {1'b0, lnEndY - lnStartY}
                                        : {1'b0, lnStartY - lnEndY};

  avg_bres_step u_step (
    .x        (cur_x),
    .y        (cur_y),
    .x1       (end_x),
    .y1       (end_y),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .dx       (dx),
    .dy       (dy),
    .err      (err),
    .x_next   (x_next),
    .y_next   (y_next),
    .err_next (err_next),
    .last     (last)
  );

`ifdef AVG_RAST_CLIP_EN
  localparam logic [11:0] X_LIM = 12'(SCREEN_W);
  localparam logic [11:0] Y_LIM = 12'(SCREEN_H);
  assign visible = ({1'b0, cur_x} < X_LIM) && ({1'b0, cur_y} < Y_LIM);
`else
  logic unused_screen;
  assign unused_screen = |{SCREEN_W, SCREEN_H};
  assign visible       = 1'b1;
`endif

  // Off-screen pixels never wait on the framebuffer.
  assign advance = pixReady || !visible;

  // The pop is combinational so the head is latched on the same edge that
  // the queue retires it; it is gated by rst_b because the state register
  // already reads IDLE while reset is held.
  assign lnRead   = rst_b && (state == RAST_IDLE) && !lnEmpty;
  assign pixWe    = (state == RAST_DRAW) && visible;
  assign busy     = (state == RAST_DRAW);
  assign pixX     = cur_x;
  assign pixY     = cur_y;
  assign pixColor = cur_color;

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      state     <= RAST_IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      end_x     <= '0;
      end_y     <= '0;
      cur_color <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
    end else begin
      case (state)
        RAST_IDLE: begin
          if (!lnEmpty) begin
            cur_x     <= lnStartX;
            cur_y     <= lnStartY;
            end_x     <= lnEndX;
            end_y     <= lnEndY;
            cur_color <= lnColor;
            sx_neg    <= (lnEndX < lnStartX);
            sy_neg    <= (lnEndY < lnStartY);
            dx        <= head_dx;
            dy        <= head_dy;
            err       <= $signed({1'b0, head_dx}) - $signed({1'b0, head_dy});
            state     <= RAST_DRAW;
          end
        end
        RAST_DRAW: begin
          if (advance) begin
            if (last) begin
              state <= RAST_IDLE;
            end else begin
              cur_x <= x_next;
              cur_y <= y_next;
              err   <= err_next;
            end
          end
        end
        default: state <= RAST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avg_line_raster.sv
// ============================================================================
// Module      : tb_avg_line_raster
// Description : Self-checking bench for avg_line_raster. A small line queue
//               model feeds the DUT; accepted pixels, pops and busy cycles
//               are recorded on the falling edge and compared against
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avg_line_raster;

  logic        clk_in = 1'b0;
  logic        rst_b;
  logic [10:0] lnStartX, lnStartY, lnEndX, lnEndY;
  logic [2:0]  lnColor;
  logic        lnEmpty;
  logic        lnRead;
  logic [10:0] pixX, pixY;
  logic [2:0]  pixColor;
  logic        pixWe;
  logic        pixReady;
  logic        busy;

  always #5 clk_in = ~clk_in;

  avg_line_raster dut (
    .clk_in   (clk_in),
    .rst_b    (rst_b),
    .lnStartX (lnStartX),
    .lnStartY (lnStartY),
    .lnEndX   (lnEndX),
    .lnEndY   (lnEndY),
    .lnColor  (lnColor),
    .lnEmpty  (lnEmpty),
    .lnRead   (lnRead),
    .pixX     (pixX),
    .pixY     (pixY),
    .pixColor (pixColor),
    .pixWe    (pixWe),
    .pixReady (pixReady),
    .busy     (busy)
  );

  // ---------------- line queue model ----------------
  logic [10:0] q_x0 [0:15];
  logic [10:0] q_y0 [0:15];
  logic [10:0] q_x1 [0:15];
  logic [10:0] q_y1 [0:15];
  logic [2:0]  q_c  [0:15];
  logic [4:0]  q_n    = '0;
  logic [4:0]  q_head = '0;

  assign lnEmpty  = (q_head >= q_n);
  assign lnStartX = q_x0[q_head[3:0]];
  assign lnStartY = q_y0[q_head[3:0]];
  assign lnEndX   = q_x1[q_head[3:0]];
  assign lnEndY   = q_y1[q_head[3:0]];
  assign lnColor  = q_c[q_head[3:0]];

  always @(posedge clk_in) if (lnRead) q_head <= q_head + 5'd1;

  task automatic push(input logic [10:0] x0, input logic [10:0] y0,
                      input logic [10:0] x1, input logic [10:0] y1,
                      input logic [2:0] c);
    q_x0[q_n[3:0]] = x0;
    q_y0[q_n[3:0]] = y0;
    q_x1[q_n[3:0]] = x1;
    q_y1[q_n[3:0]] = y1;
    q_c[q_n[3:0]]  = c;
    q_n = q_n + 5'd1;
  endtask

  // ---------------- monitor ----------------
  logic [10:0] cap_x [$];
  logic [10:0] cap_y [$];
  logic [2:0]  cap_c [$];
  int          rd_count = 0;
  int          busy_cnt = 0;

  always @(negedge clk_in) begin
    if (pixWe && pixReady) begin
      cap_x.push_back(pixX);
      cap_y.push_back(pixY);
      cap_c.push_back(pixColor);
    end
    if (lnRead) rd_count <= rd_count + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (lnRead) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_px(input string tag, input int idx, input int ex,
                          input int ey, input int ec);
    if (idx < cap_x.size()) begin
      check({tag, " x"}, int'(cap_x[idx]), ex);
      check({tag, " y"}, int'(cap_y[idx]), ey);
      check({tag, " color"}, int'(cap_c[idx]), ec);
    end
  endtask

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [2:0]  c;
    logic [4:0]  first;
    logic [3:0]  n;
    logic [3:0]  nb;
  } vec_t;

  localparam int NV = 6;
  vec_t        vt [0:NV-1];
  logic [21:0] ep [0:31];

  initial begin
    int bc, br, bb;
    bit ok;
    logic [10:0] s1x [0:2];

    // (0,0)->(3,0)
    vt[0] = '{x0:11'd0, y0:11'd0, x1:11'd3, y1:11'd0, c:3'd5, first:5'd0, n:4'd4, nb:4'd4};
    ep[0] = {11'd0, 11'd0}; ep[1] = {11'd1, 11'd0}; ep[2] = {11'd2, 11'd0}; ep[3] = {11'd3, 11'd0};
    // (10,10)->(7,14): y-major, x decreasing
    vt[1] = '{x0:11'd10, y0:11'd10, x1:11'd7, y1:11'd14, c:3'd2, first:5'd4, n:4'd5, nb:4'd5};
    ep[4] = {11'd10, 11'd10}; ep[5] = {11'd9, 11'd11}; ep[6] = {11'd9, 11'd12};
    ep[7] = {11'd8, 11'd13};  ep[8] = {11'd7, 11'd14};
    // degenerate
    vt[2] = '{x0:11'd2, y0:11'd2, x1:11'd2, y1:11'd2, c:3'd7, first:5'd9, n:4'd1, nb:4'd1};
    ep[9] = {11'd2, 11'd2};
    // (5,3)->(0,1): x-major, both directions negative
    vt[3] = '{x0:11'd5, y0:11'd3, x1:11'd0, y1:11'd1, c:3'd3, first:5'd10, n:4'd6, nb:4'd6};
    ep[10] = {11'd5, 11'd3}; ep[11] = {11'd4, 11'd3}; ep[12] = {11'd3, 11'd2};
    ep[13] = {11'd2, 11'd2}; ep[14] = {11'd1, 11'd1}; ep[15] = {11'd0, 11'd1};
    // vertical upward
    vt[4] = '{x0:11'd3, y0:11'd4, x1:11'd3, y1:11'd1, c:3'd1, first:5'd16, n:4'd4, nb:4'd4};
    ep[16] = {11'd3, 11'd4}; ep[17] = {11'd3, 11'd3}; ep[18] = {11'd3, 11'd2}; ep[19] = {11'd3, 11'd1};
    // top of the coordinate range (entirely off-screen when clipping)
`ifdef AVG_RAST_CLIP_EN
    vt[5] = '{x0:11'd2047, y0:11'd2047, x1:11'd2045, y1:11'd2047, c:3'd6, first:5'd20, n:4'd0, nb:4'd3};
`else
    vt[5] = '{x0:11'd2047, y0:11'd2047, x1:11'd2045, y1:11'd2047, c:3'd6, first:5'd20, n:4'd3, nb:4'd3};
`endif
    ep[20] = {11'd2047, 11'd2047}; ep[21] = {11'd2046, 11'd2047}; ep[22] = {11'd2045, 11'd2047};

    // ---------------- reset state ----------------
    rst_b    = 1'b0;
    pixReady = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset lnRead", int'(lnRead), 0);
    check("reset pixWe", int'(pixWe), 0);
    check("reset busy", int'(busy), 0);
    check("reset pixX", int'(pixX), 0);
    check("reset pixY", int'(pixY), 0);
    check("reset pixColor", int'(pixColor), 0);
    rst_b = 1'b1;

    // ---------------- empty queue stays idle ----------------
    repeat (3) @(posedge clk_in);
    #1;
    check("idle lnRead", int'(lnRead), 0);
    check("idle busy", int'(busy), 0);
    check("idle pops", rd_count, 0);

    // ---------------- table-driven single lines, pixReady=1 ----------------
    for (int i = 0; i < NV; i++) begin
      bc = cap_x.size(); br = rd_count; bb = busy_cnt;
      push(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].c);
      repeat (14) @(posedge clk_in);
      #1;
      check($sformatf("v%0d pixel count", i), cap_x.size() - bc, int'(vt[i].n));
      check($sformatf("v%0d pops", i), rd_count - br, 1);
      check($sformatf("v%0d busy cycles", i), busy_cnt - bb, int'(vt[i].nb));
      for (int j = 0; j < int'(vt[i].n); j++)
        check_px($sformatf("v%0d px%0d", i, j), bc + j,
                 int'(ep[int'(vt[i].first) + j][21:11]),
                 int'(ep[int'(vt[i].first) + j][10:0]), int'(vt[i].c));
    end

    // ---------------- back-to-back lines ----------------
    bc = cap_x.size(); br = rd_count; bb = busy_cnt;
    push(11'd1, 11'd1, 11'd2, 11'd1, 3'd4);
    push(11'd7, 11'd0, 11'd7, 11'd1, 3'd1);
    repeat (14) @(posedge clk_in);
    #1;
    check("b2b pixel count", cap_x.size() - bc, 4);
    check("b2b pops", rd_count - br, 2);
    check("b2b busy cycles", busy_cnt - bb, 4);
    check_px("b2b px0", bc + 0, 1, 1, 4);
    check_px("b2b px1", bc + 1, 2, 1, 4);
    check_px("b2b px2", bc + 2, 7, 0, 1);
    check_px("b2b px3", bc + 3, 7, 1, 1);

    // ---------------- backpressure on alternating cycles ----------------
    s1x[0] = 11'd0; s1x[1] = 11'd1; s1x[2] = 11'd2;
    bc = cap_x.size();
    pixReady = 1'b0;
    push(11'd0, 11'd0, 11'd2, 11'd2, 3'd3);
    wait_pop(ok);
    check("bp pop seen", int'(ok), 1);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk_in);
      #1;
      pixReady = (cyc % 2 == 1);
      @(negedge clk_in);
      check($sformatf("bp cyc%0d pixWe", cyc), int'(pixWe), 1);
      check($sformatf("bp cyc%0d pixX", cyc), int'(pixX), int'(s1x[cyc / 2]));
      check($sformatf("bp cyc%0d pixY", cyc), int'(pixY), int'(s1x[cyc / 2]));
    end
    @(posedge clk_in);
    #1;
    pixReady = 1'b1;
    @(negedge clk_in);
    check("bp busy after", int'(busy), 0);
    check("bp pixel count", cap_x.size() - bc, 3);
    for (int j = 0; j < 3; j++)
      check_px($sformatf("bp px%0d", j), bc + j, int'(s1x[j]), int'(s1x[j]), 3);
    @(posedge clk_in);
    #1;

    // ---------------- clipping boundary ----------------
    bc = cap_x.size(); bb = busy_cnt;
    push(11'd638, 11'd0, 11'd641, 11'd0, 3'd2);
    repeat (12) @(posedge clk_in);
    #1;
    check("clip busy cycles", busy_cnt - bb, 4);
`ifdef AVG_RAST_CLIP_EN
    check("clip pixel count", cap_x.size() - bc, 2);
`else
    check("clip pixel count", cap_x.size() - bc, 4);
    check_px("clip px2", bc + 2, 640, 0, 2);
    check_px("clip px3", bc + 3, 641, 0, 2);
`endif
    check_px("clip px0", bc + 0, 638, 0, 2);
    check_px("clip px1", bc + 1, 639, 0, 2);

    // ---------------- reset mid-line with a second line queued ----------------
    push(11'd0, 11'd5, 11'd3, 11'd5, 3'd3);
    push(11'd4, 11'd4, 11'd5, 11'd5, 3'd6);
    wait_pop(ok);
    check("rst pop seen", int'(ok), 1);
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    check("rst pre pixX", int'(pixX), 1);
    rst_b = 1'b0;
    #1;
    check("rst lnRead", int'(lnRead), 0);
    check("rst pixWe", int'(pixWe), 0);
    check("rst busy", int'(busy), 0);
    check("rst pixX", int'(pixX), 0);
    check("rst pixY", int'(pixY), 0);
    check("rst pixColor", int'(pixColor), 0);
    bc = cap_x.size(); br = rd_count;
    repeat (2) @(posedge clk_in);
    #1;
    rst_b = 1'b1;
    repeat (12) @(posedge clk_in);
    #1;
    check("rst later pops", rd_count - br, 1);
    check("rst later pixels", cap_x.size() - bc, 2);
    check_px("rst px0", bc + 0, 4, 4, 6);
    check_px("rst px1", bc + 1, 5, 5, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/avg_line_raster.md
AVG_LINE_RASTER -- requirements
Module: avg_line_raster

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal pixel count for clipping.
REQ-002 SHALL have parameter SCREEN_H, default 480, vertical pixel count for clipping.
REQ-003 SHALL have port clk_in  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports lnStartX, lnStartY, lnEndX, lnEndY  input  11 each  line at queue head, unsigned pixel coordinates.
REQ-006 SHALL have port lnColor  input  3  colour at queue head.
REQ-007 SHALL have port lnEmpty  input  1  line queue empty.
REQ-008 SHALL have port lnRead  output  1  one-cycle pop of queue head.
REQ-009 SHALL have ports pixX, pixY  output  11 each  current pixel coordinate.
REQ-010 SHALL have port pixColor  output  3  current pixel colour.
REQ-011 SHALL have port pixWe  output  1  pixel write valid.
REQ-012 SHALL have port pixReady  input  1  framebuffer accepts pixel this cycle.
REQ-013 SHALL have port busy  output  1  a line is being drawn.

Function
REQ-014 SHALL implement states IDLE and DRAW only.
REQ-015 IDLE with lnEmpty=0: SHALL assert lnRead for exactly one cycle, latch all head fields on the same edge, and enter DRAW on the next cycle.
REQ-016 IDLE with lnEmpty=1: lnRead SHALL stay 0 and state SHALL stay IDLE.
REQ-017 lnRead SHALL never be asserted outside IDLE, nor while lnEmpty=1.
REQ-018 Drawing SHALL use integer Bresenham over all octants: dx=|x1-x0| and dy=|y1-y0| as 12-bit values; error term 13-bit signed; step directions sx and sy equal to +/-1.
REQ-019 DRAW SHALL emit exactly max(dx,dy)+1 pixels, the first at (x0,y0) and the last at (x1,y1).
REQ-020 In DRAW, pixWe=1 with pixX/pixY/pixColor held stable until pixReady=1; a pixel transfers on the cycle where pixWe and pixReady are both 1.
REQ-021 On a transfer the rasterizer SHALL advance to the next pixel in the following cycle, giving 1 pixel/cycle peak throughput.
REQ-022 The transfer of the last pixel SHALL return the state to IDLE; the next pop may occur in that IDLE cycle.
REQ-023 A degenerate line (start == end) SHALL emit one pixel.
REQ-024 busy SHALL be 1 in DRAW and 0 in IDLE.
REQ-025 Head fields changing while in DRAW SHALL have no effect.

Reset
REQ-026 rst_b low SHALL immediately force IDLE with lnRead=0, pixWe=0, busy=0, pixX=0, pixY=0, pixColor=0, and all internal registers cleared.
REQ-027 Reset mid-line SHALL abandon the line without popping or emitting further pixels; the popped line is lost.

Configuration
REQ-028 With AVG_RAST_CLIP_EN defined, pixels with x>=SCREEN_W or y>=SCREEN_H SHALL be stepped through internally at one per cycle with pixWe=0 and without waiting for pixReady.
REQ-029 Without AVG_RAST_CLIP_EN, every pixel SHALL be emitted regardless of coordinate, and SCREEN_W and SCREEN_H SHALL be unused.

Structure
REQ-030 Shared package avg_pkg SHALL hold coord_t (11-bit), color_t (3-bit), the rast_state_t enum, and the SCREEN_W and SCREEN_H defaults.
REQ-031 A single sub-module avg_bres_step SHALL compute next x, next y, next error and a last flag from the current state; it SHALL be combinational, with registers kept in the parent.

Verification
REQ-032 Queue supplies (0,0)->(3,0), colour 5, pixReady=1 -> one lnRead pulse, then pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, all with colour 5, then IDLE.
REQ-033 Line (10,10)->(7,14) -> 5 pixels: (10,10),(9,11),(9,12),(8,13),(7,14), with y stepping every pixel.
REQ-034 Line (2,2)->(2,2) -> exactly one pixel (2,2) and busy high for 1 cycle at pixReady=1.
REQ-035 Line (0,0)->(2,2) with pixReady low on alternating cycles -> each pixel held stable until accepted; 3 pixels over 6 cycles; no duplicate and no skipped pixel.
REQ-036 With AVG_RAST_CLIP_EN defined, line (638,0)->(641,0) -> only (638,0) and (639,0) have pixWe=1; return to IDLE 4 cycles after DRAW entry.
REQ-037 rst_b low during the second pixel of a 4-pixel line, with 2 lines queued -> outputs at reset values at once; after release, exactly one further lnRead, for the second line.
